// File: rtl/apb_coeff_loader.sv
// APB slave that forwards FIR tap coefficients to the filter bank over a
// valid/ack handshake, tracks a per-band tap index and pulses AttenLatch.
// Optional feature macro: COEF_READBACK_EN (per-band last-acked tap readback).
module apb_coeff_loader #(
  parameter int unsigned NBANDS = 5,
  parameter int unsigned NTAPS  = 163,
  parameter int unsigned IDXW   = 9
) (
  input  logic            Clk,
  input  logic            Reset_,
  input  logic [31:0]     PAddr,
  input  logic [31:0]     PWData,
  input  logic            PSel,
  input  logic            PEnable,
  input  logic            PWrite,
  output logic [31:0]     PRData,
  output logic            CoefWrEn,
  output logic [3:0]      CoefBand,
  output logic [IDXW-1:0] CoefIndex,
  output logic [15:0]     CoefData,
  input  logic            CoefAck,
  output logic            AttenLatch
);

  localparam int unsigned BANDW = 4;
  localparam int unsigned TAPW  = 16;
  localparam int unsigned STATW = 9;

  localparam logic [2:0] CMD_LOAD   = 3'b001;
  localparam logic [2:0] CMD_ATTEN  = 3'b010;
  localparam logic [2:0] CMD_REWIND = 3'b100;

  typedef enum logic [0:0] {ST_IDLE, ST_REQ} state_e;

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic              atten_q, atten_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BANDW-1:0]  band_q, band_d;
  logic [IDXW-1:0]   index_q, index_d;
  logic [TAPW-1:0]   data_q, data_d;
  logic [IDXW-1:0]   idx_q [NBANDS];
  logic [IDXW-1:0]   idx_d [NBANDS];
  logic [NBANDS-1:0] full_q, full_d;
`ifdef COEF_READBACK_EN
  logic [TAPW-1:0]   last_q [NBANDS];
  logic [TAPW-1:0]   last_d [NBANDS];
`endif

  logic             wr_commit_c, rd_commit_c;
  logic             addr_is_band_c, addr_is_ctrl_c;
  logic [BANDW-1:0] addr_band_c, sel_band_c;
  logic [2:0]       cmd_c;
  logic [TAPW-1:0]  tap_c;
  logic             unused_bits_c;

  // Access qualification and address/field decode
  always_comb begin
    wr_commit_c    = PSel & PEnable & PWrite;
    rd_commit_c    = PSel & PEnable & ~PWrite;
    addr_band_c    = PAddr[7:4];
    addr_is_band_c = (PAddr[3:0] == 4'd0) && (addr_band_c >= 4'd1) &&
                     (addr_band_c <= BANDW'(NBANDS));
    addr_is_ctrl_c = (PAddr[7:0] == 8'hB0);
    sel_band_c     = addr_is_band_c ? addr_band_c : band_q;
    cmd_c          = PWData[2:0];
    tap_c          = PWData[18:3];
  end

  assign unused_bits_c = ^{PAddr[31:8], PWData[31:19]};

  // Next-state: handshake completion first, then bus writes (REWIND overrides ACK)
  always_comb begin
    state_d = state_q;
    atten_d = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    band_d  = band_q;
    index_d = index_q;
    data_d  = data_q;
    idx_d   = idx_q;
    full_d  = full_q;
`ifdef COEF_READBACK_EN
    last_d  = last_q;
`endif

    if (state_q == ST_REQ && CoefAck) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      for (int i = 0; i < int'(NBANDS); i++) begin
        if (band_q == BANDW'(i + 1)) begin
          if (idx_q[i] == IDXW'(NTAPS - 1)) begin
            idx_d[i]  = '0;
            full_d[i] = 1'b1;
          end else begin
            idx_d[i] = idx_q[i] + IDXW'(1);
          end
`ifdef COEF_READBACK_EN
          last_d[i] = data_q;
`endif
        end
      end
    end

    if (wr_commit_c) begin
      if (addr_is_band_c) begin
        if (cmd_c == CMD_LOAD) begin
          if (state_q == ST_IDLE) begin
            state_d = ST_REQ;
            done_d  = 1'b0;
            band_d  = addr_band_c;
            data_d  = tap_c;
            for (int i = 0; i < int'(NBANDS); i++) begin
              if (addr_band_c == BANDW'(i + 1)) index_d = idx_q[i];
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (cmd_c == CMD_REWIND) begin
          for (int i = 0; i < int'(NBANDS); i++) begin
            if (addr_band_c == BANDW'(i + 1)) begin
              idx_d[i]  = '0;
              full_d[i] = 1'b0;
            end
          end
        end
      end else if (addr_is_ctrl_c) begin
        if (cmd_c == CMD_ATTEN) atten_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (rd_commit_c && addr_is_ctrl_c) err_d = 1'b0;

    wr_en_d = (state_d == ST_REQ);
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      atten_q <= 1'b0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
      band_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      full_q  <= '0;
      for (int i = 0; i < int'(NBANDS); i++) begin
        idx_q[i] <= '0;
`ifdef COEF_READBACK_EN
        last_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      atten_q <= atten_d;
      done_q  <= done_d;
      err_q   <= err_d;
      band_q  <= band_d;
      index_q <= index_d;
      data_q  <= data_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
`ifdef COEF_READBACK_EN
      last_q  <= last_d;
`endif
    end
  end

  // Status word for the decoded (or last captured) band
  always_comb begin
    logic [IDXW-1:0] sel_idx;
    logic            sel_full;
    sel_idx  = '0;
    sel_full = 1'b0;
    for (int i = 0; i < int'(NBANDS); i++) begin
      if (sel_band_c == BANDW'(i + 1)) begin
        sel_idx  = idx_q[i];
        sel_full = full_q[i];
      end
    end
    PRData = {done_q, err_q, sel_full, 20'b0, STATW'(sel_idx)};
`ifdef COEF_READBACK_EN
    if (PSel && addr_is_band_c) begin
      for (int i = 0; i < int'(NBANDS); i++) begin
        if (addr_band_c == BANDW'(i + 1)) PRData[28:13] = last_q[i];
      end
    end
`endif
  end

  assign CoefWrEn   = wr_en_q;
  assign CoefBand   = band_q;
  assign CoefIndex  = index_q;
  assign CoefData   = data_q;
  assign AttenLatch = atten_q;

endmodule
